// File: rtl/shift32_seq_pkg.sv
// Shared EX-stage definitions: shifter type encodings and sequencer state encoding.
package shift32_seq_pkg;

    localparam logic [1:0] SH_LEFT   = 2'b00;
    localparam logic [1:0] SH_LRIGHT = 2'b10;
    localparam logic [1:0] SH_ARIGHT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PA   = 3'd1,
        ST_PB   = 3'd2,
        ST_PC   = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/bshifter16.sv
// 16-bit combinational barrel shifter: typ 00/01 left, 10 logical right, 11 arithmetic right.
module bshifter16
    import shift32_seq_pkg::*;
(
    input  logic [15:0] datain,
    input  logic [1:0]  typ,
    input  logic [3:0]  shiftnum,
    output logic [15:0] dataout
);

    always_comb begin
        dataout = datain << shiftnum;
        case (typ)
            SH_LRIGHT: dataout = datain >> shiftnum;
            SH_ARIGHT: dataout = $signed(datain) >>> shiftnum;
            default:   dataout = datain << shiftnum;
        endcase
    end

endmodule

// File: rtl/shift32_seq.sv
// 32-bit shift sequencer: reuses one 16-bit barrel shifter over up to three passes.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// PA    | first pass: main half (or the only pass when n >= 16)
// PB    | cross-half spill bits computed into spill_q
// PC    | second half shifted and OR-merged with spill_q
// DONE  | result held on rsp_data until rsp_ready
module shift32_seq
    import shift32_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_typ,
    input  logic [4:0]  req_shamt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [15:0] hi_q, hi_d;
    logic [15:0] lo_q, lo_d;
    logic [1:0]  typ_q, typ_d;
    logic [4:0]  n_q, n_d;
    logic [15:0] spill_q, spill_d;
    logic [15:0] res_hi_q, res_hi_d;
    logic [15:0] res_lo_q, res_lo_d;

    logic [15:0] core_din;
    logic [1:0]  core_typ;
    logic [3:0]  core_k;
    logic [15:0] core_out;
    logic        is_left;
    logic [3:0]  m;

    assign is_left = ~typ_q[1];
    // 16 - n modulo 16, valid for the 1..15 range where it is used
    assign m       = 4'd0 - n_q[3:0];

    always_comb begin
        core_din = lo_q;
        core_typ = SH_LEFT;
        core_k   = n_q[3:0];
        case (state_q)
            ST_PA: begin
                if (is_left) begin
                    core_din = lo_q;
                    core_typ = SH_LEFT;
                end else begin
                    core_din = hi_q;
                    core_typ = typ_q;
                end
                core_k = n_q[3:0];
            end
            ST_PB: begin
                if (is_left) begin
                    core_din = lo_q;
                    core_typ = SH_LRIGHT;
                end else begin
                    core_din = hi_q;
                    core_typ = SH_LEFT;
                end
                core_k = m;
            end
            ST_PC: begin
                if (is_left) begin
                    core_din = hi_q;
                    core_typ = SH_LEFT;
                end else begin
                    core_din = lo_q;
                    core_typ = SH_LRIGHT;
                end
                core_k = n_q[3:0];
            end
            default: ;
        endcase
    end

    bshifter16 u_core (
        .datain   (core_din),
        .typ      (core_typ),
        .shiftnum (core_k),
        .dataout  (core_out)
    );

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        typ_d    = typ_q;
        n_d      = n_q;
        spill_d  = spill_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    hi_d  = req_data[31:16];
                    lo_d  = req_data[15:0];
                    typ_d = req_typ;
                    n_d   = req_shamt;
                    if (req_shamt == 5'd0) begin
                        res_hi_d = req_data[31:16];
                        res_lo_d = req_data[15:0];
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_PA;
                    end
                end
            end
            ST_PA: begin
                if (n_q[4]) begin
                    // Whole half moves across; the vacated half is zero or sign fill
                    if (is_left) begin
                        res_hi_d = core_out;
                        res_lo_d = 16'h0000;
                    end else begin
                        res_lo_d = core_out;
                        res_hi_d = {16{hi_q[15] & typ_q[0]}};
                    end
                    state_d = ST_DONE;
                end else begin
                    if (is_left) res_lo_d = core_out;
                    else         res_hi_d = core_out;
                    state_d = ST_PB;
                end
            end
            ST_PB: begin
                spill_d = core_out;
                state_d = ST_PC;
            end
            ST_PC: begin
                if (is_left) res_hi_d = core_out | spill_q;
                else         res_lo_d = core_out | spill_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            typ_q    <= '0;
            n_q      <= '0;
            spill_q  <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            typ_q    <= typ_d;
            n_q      <= n_d;
            spill_q  <= spill_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_data  = {res_hi_q, res_lo_q};

endmodule

// File: tb/tb_shift32_seq.sv
// Directed-vector and random-sweep bench for the 32-bit shift sequencer.
module tb_shift32_seq;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_data;
    logic [1:0]  req_typ;
    logic [4:0]  req_shamt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    shift32_seq dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_typ   (req_typ),
        .req_shamt (req_shamt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  typ;
        logic [4:0]  shamt;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [1:0] t,
                                              input logic [4:0] s);
        logic [31:0] r;
        if (t == 2'b10)      r = d >> s;
        else if (t == 2'b11) r = $signed(d) >>> s;
        else                 r = d << s;
        return r;
    endfunction

    function automatic int ref_lat(input logic [4:0] s);
        if (s == 5'd0)  return 1;
        if (s >= 5'd16) return 2;
        return 4;
    endfunction

    // Called just after a negedge with the block idle; returns just after a negedge, idle again.
    task automatic run_op(input logic [31:0] d, input logic [1:0] t, input logic [4:0] s,
                          input int hold, output logic [31:0] res, output int lat);
        req_valid = 1'b1;
        req_data  = d;
        req_typ   = t;
        req_shamt = s;
        chk("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) chk("rsp_valid_timeout", 32'd0, 32'd1);
        res = rsp_data;
        chk("req_ready_in_done", {31'b0, req_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_rsp_data_stable", rsp_data, res);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("idle_after_handshake_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("idle_after_handshake_req_ready", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] res;
        int          lat;
        logic [31:0] rd;
        logic [1:0]  rt;
        logic [4:0]  rs;

        vecs[0]  = '{32'h0000_8001, 2'b00, 5'd4,  32'h0008_0010, 4};
        vecs[1]  = '{32'h8000_0010, 2'b11, 5'd4,  32'hF800_0001, 4};
        vecs[2]  = '{32'h8000_0010, 2'b10, 5'd4,  32'h0800_0001, 4};
        vecs[3]  = '{32'h8000_0000, 2'b11, 5'd20, 32'hFFFF_F800, 2};
        vecs[4]  = '{32'h8000_0000, 2'b10, 5'd20, 32'h0000_0800, 2};
        vecs[5]  = '{32'h0000_1234, 2'b00, 5'd16, 32'h1234_0000, 2};
        vecs[6]  = '{32'hDEAD_BEEF, 2'b00, 5'd0,  32'hDEAD_BEEF, 1};
        vecs[7]  = '{32'h0000_0001, 2'b00, 5'd31, 32'h8000_0000, 2};
        vecs[8]  = '{32'h0000_0001, 2'b01, 5'd31, 32'h8000_0000, 2};
        vecs[9]  = '{32'hF000_0000, 2'b11, 5'd31, 32'hFFFF_FFFF, 2};
        vecs[10] = '{32'h1234_5678, 2'b01, 5'd8,  32'h3456_7800, 4};
        vecs[11] = '{32'h1234_5678, 2'b10, 5'd15, 32'h0000_2468, 4};
        vecs[12] = '{32'h8000_0000, 2'b11, 5'd1,  32'hC000_0000, 4};
        vecs[13] = '{32'hDEAD_BEEF, 2'b11, 5'd0,  32'hDEAD_BEEF, 1};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_data  = '0;
        req_typ   = '0;
        req_shamt = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_busy",      {31'b0, busy},      32'd0);
        chk("reset_rsp_data",  rsp_data,           32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].data, vecs[i].typ, vecs[i].shamt, 0, res, lat);
            chk($sformatf("vec%0d_data", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure, then a back-to-back request right after release
        run_op(32'h0000_8001, 2'b00, 5'd4, 5, res, lat);
        chk("bp_data", res, 32'h0008_0010);
        run_op(32'h1234_5678, 2'b10, 5'd15, 0, res, lat);
        chk("after_bp_data", res, 32'h0000_2468);
        chk("after_bp_latency", 32'(lat), 32'd4);

        // Abort a three-pass op while in PB
        req_valid = 1'b1;
        req_data  = 32'hFFFF_FFFF;
        req_typ   = 2'b11;
        req_shamt = 5'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy_in_pb", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
        chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("abort_busy",      {31'b0, busy},      32'd0);
        chk("abort_rsp_data",  rsp_data,           32'd0);
        run_op(32'h0000_0003, 2'b00, 5'd2, 0, res, lat);
        chk("after_abort_data", res, 32'h0000_000C);
        chk("after_abort_latency", 32'(lat), 32'd4);

        for (int i = 0; i < 1000; i++) begin
            rd = $urandom;
            rt = 2'($urandom_range(0, 3));
            rs = 5'($urandom_range(0, 31));
            run_op(rd, rt, rs, 0, res, lat);
            chk("rand_data", res, ref_shift(rd, rt, rs));
            chk("rand_latency", 32'(lat), 32'(ref_lat(rs)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
